// File: rtl/sm_hex_display_pkg.sv
// Shared constants for the seven-segment display multiplexer: decode table,
// segment bit positions and the digit-index width helper.
package sm_hex_display_pkg;

  // Bit positions inside the 8-bit {dp,g,f,e,d,c,b,a} segment bus
  localparam int SEG_A  = 0;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  // Hex nibble to segments a..g, 1 = lit
  localparam logic [6:0] SEG7 [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  // Width of a counter that indexes n digits; a single digit still needs one bit
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sm_hex_display_mux_hex_to_seg7.sv
// Combinational hex nibble to seven-segment decoder (active-high segments).
module hex_to_seg7
  import sm_hex_display_pkg::*;
(
  input  logic [3:0]         nibble,
  output logic [SEG_G:SEG_A] seg7
);

  assign seg7 = SEG7[nibble];

endmodule

// File: rtl/sm_hex_display_mux.sv
// Time-multiplexed seven-segment driver. Scans NUM_DIGITS digits with a
// 2^DIV_BITS-clock slot, dims with a 4-bit PWM, and double-buffers the display
// data so new values only appear at a frame boundary.
module sm_hex_display_mux
  import sm_hex_display_pkg::*;
#(
  parameter int NUM_DIGITS     = 3,
  parameter int DIV_BITS       = 10,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit DIG_ACTIVE_LOW = 1'b0
) (
  input  logic                    clkin,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] hex_value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic                    load,
  input  logic [3:0]              brightness,
  output logic [7:0]              seg,
  output logic [NUM_DIGITS-1:0]   dig_sel,
  output logic                    frame_start
);

  localparam int                    IW       = idx_width(NUM_DIGITS);
  localparam logic [IW-1:0]         LAST_IDX = IW'(NUM_DIGITS - 1);
  localparam logic [7:0]            SEG_OFF  = {8{SEG_ACTIVE_LOW}};
  localparam logic [NUM_DIGITS-1:0] DIG_OFF  = {NUM_DIGITS{DIG_ACTIVE_LOW}};

  logic [DIV_BITS-1:0]     pre;
  logic [IW-1:0]           idx;
  logic                    slot_tick;
  logic                    wrap_tick;

  logic [4*NUM_DIGITS-1:0] pend_hex;
  logic [NUM_DIGITS-1:0]   pend_dp;
  logic [NUM_DIGITS-1:0]   pend_blank;
  logic                    pend_flag;
  logic [4*NUM_DIGITS-1:0] act_hex;
  logic [NUM_DIGITS-1:0]   act_dp;
  logic [NUM_DIGITS-1:0]   act_blank;

  logic                    first_q;
  logic [3:0]              cur_nib;
  logic                    cur_dp;
  logic                    cur_blank;
  logic [NUM_DIGITS-1:0]   dig_onehot;
  logic [SEG_G:SEG_A]      seg7;
  logic [7:0]              seg_raw;
  logic [3:0]              phase;
  logic                    lit;

  assign slot_tick = &pre;
  assign wrap_tick = slot_tick && (idx == LAST_IDX);
  assign phase     = pre[DIV_BITS-1 -: 4];

  // Prescaler and digit index; idx wraps explicitly so odd digit counts never overrun
  always_ff @(posedge clkin) begin
    if (reset) begin
      pre <= '0;
      idx <= '0;
    end else begin
      pre <= pre + 1'b1;
      if (slot_tick) begin
        idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
      end
    end
  end

  // Pending/active buffers; a load coinciding with the wrap tick bypasses pending
  always_ff @(posedge clkin) begin
    if (reset) begin
      pend_hex   <= '0;
      pend_dp    <= '0;
      pend_blank <= '0;
      pend_flag  <= 1'b0;
      act_hex    <= '0;
      act_dp     <= '0;
      act_blank  <= '1;
    end else if (wrap_tick) begin
      pend_flag <= 1'b0;
      if (load) begin
        act_hex   <= hex_value;
        act_dp    <= dp_in;
        act_blank <= blank_in;
      end else if (pend_flag) begin
        act_hex   <= pend_hex;
        act_dp    <= pend_dp;
        act_blank <= pend_blank;
      end
    end else if (load) begin
      pend_hex   <= hex_value;
      pend_dp    <= dp_in;
      pend_blank <= blank_in;
      pend_flag  <= 1'b1;
    end
  end

  // Select the active digit's data and its one-hot enable
  always_comb begin
    cur_nib    = '0;
    cur_dp     = 1'b0;
    cur_blank  = 1'b1;
    dig_onehot = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IW'(i)) begin
        cur_nib       = act_hex[4*i +: 4];
        cur_dp        = act_dp[i];
        cur_blank     = act_blank[i];
        dig_onehot[i] = 1'b1;
      end
    end
  end

  hex_to_seg7 u_dec (
    .nibble (cur_nib),
    .seg7   (seg7)
  );

  // Assemble the active-high segment word and the PWM/blank lit decision
  always_comb begin
    seg_raw              = '0;
    seg_raw[SEG_G:SEG_A] = seg7;
    seg_raw[SEG_DP]      = cur_dp;
    lit                  = !cur_blank && ((brightness == 4'hF) || (phase < brightness));
  end

  // Marks the first cycle after reset so frame_start pulses then too
  always_ff @(posedge clkin) begin
    if (reset) begin
      first_q <= 1'b1;
    end else begin
      first_q <= 1'b0;
    end
  end

  // Registered pins: seg and dig_sel update on the same edge, so no mixed-digit cycle
  always_ff @(posedge clkin) begin
    if (reset) begin
      seg         <= SEG_OFF;
      dig_sel     <= DIG_OFF;
      frame_start <= 1'b0;
    end else begin
      seg         <= lit ? (seg_raw ^ SEG_OFF) : SEG_OFF;
      dig_sel     <= lit ? (dig_onehot ^ DIG_OFF) : DIG_OFF;
      frame_start <= wrap_tick | first_q;
    end
  end

endmodule

// File: tb/tb_sm_hex_display_mux.sv
// Directed bench for sm_hex_display_mux: three instances (3 digits/16-clock slot,
// 3 digits/64-clock slot, 5 digits/16-clock slot) with a scoreboard of expected
// per-digit pin values queued at load time and checked across each frame.
module tb_sm_hex_display_mux;

  typedef struct packed {
    logic [7:0] seg;
    logic [7:0] dig;
  } exp_t;

  logic        clk;
  logic        reset;
  logic [11:0] hex;
  logic [2:0]  dp;
  logic [2:0]  blank;
  logic        load;
  logic [3:0]  bright;
  logic [19:0] hex2;
  logic [4:0]  dp2;
  logic [4:0]  blank2;
  logic        load2;

  logic [7:0]  seg0, seg1, seg2;
  logic [2:0]  dig0, dig1;
  logic [4:0]  dig2;
  logic        fs0, fs1, fs2;

  exp_t sb0[$];
  exp_t sb2[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  sm_hex_display_mux #(.NUM_DIGITS(3), .DIV_BITS(4), .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(0)) dut0 (
    .clkin(clk), .reset(reset), .hex_value(hex), .dp_in(dp), .blank_in(blank), .load(load),
    .brightness(bright), .seg(seg0), .dig_sel(dig0), .frame_start(fs0));

  sm_hex_display_mux #(.NUM_DIGITS(3), .DIV_BITS(6), .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(0)) dut1 (
    .clkin(clk), .reset(reset), .hex_value(hex), .dp_in(dp), .blank_in(blank), .load(load),
    .brightness(bright), .seg(seg1), .dig_sel(dig1), .frame_start(fs1));

  sm_hex_display_mux #(.NUM_DIGITS(5), .DIV_BITS(4), .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(0)) dut2 (
    .clkin(clk), .reset(reset), .hex_value(hex2), .dp_in(dp2), .blank_in(blank2), .load(load2),
    .brightness(bright), .seg(seg2), .dig_sel(dig2), .frame_start(fs2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] ref_dec(input logic [3:0] n);
    case (n)
      4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
      4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
      4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
      4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
    endcase
  endfunction

  // Expected pins for one digit slot at full brightness (segments active-low, digits active-high)
  function automatic exp_t mk(input logic [3:0] n, input logic d, input logic b, input int pos);
    exp_t e;
    if (b) begin
      e.seg = 8'hFF;
      e.dig = 8'h00;
    end else begin
      e.seg = ~{d, ref_dec(n)};
      e.dig = 8'(1 << pos);
    end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic push0(input logic [11:0] h, input logic [2:0] d, input logic [2:0] b);
    for (int i = 0; i < 3; i++) sb0.push_back(mk(h[4*i +: 4], d[i], b[i], i));
  endtask

  task automatic wait_fs(input int which, input int limit, input string tag);
    int   n = 0;
    logic f;
    do begin
      @(negedge clk);
      n++;
      f = (which == 0) ? fs0 : (which == 1) ? fs1 : fs2;
    end while (f !== 1'b1 && n < limit);
    chk({tag, "_seen"}, {31'b0, f}, 32'd1);
  endtask

  // Called on the frame_start cycle; checks every cycle of the following frame
  task automatic check_frame(input int which, input int nd, input string tag);
    exp_t       e[8];
    int         bad = 0;
    int         d;
    int         depth;
    logic [7:0] os, od;
    logic       of;
    depth = (which == 0) ? sb0.size() : sb2.size();
    chk({tag, "_sb_depth"}, depth, nd);
    if (depth < nd) return;
    for (int i = 0; i < nd; i++) e[i] = (which == 0) ? sb0.pop_front() : sb2.pop_front();
    of = 1'b0;
    for (int k = 1; k <= nd * 16; k++) begin
      @(negedge clk);
      d  = (k - 1) / 16;
      os = (which == 0) ? seg0 : seg2;
      od = (which == 0) ? {5'b0, dig0} : {3'b0, dig2};
      of = (which == 0) ? fs0 : fs2;
      if (os !== e[d].seg || od !== e[d].dig) bad++;
      if ((k - 1) % 16 == 7) chk($sformatf("%s_d%0d", tag, d), {os, od}, {e[d].seg, e[d].dig});
    end
    chk({tag, "_every_cycle"}, bad, 0);
    chk({tag, "_frame_len"}, {31'b0, of}, 32'd1);
  endtask

  // Called on the frame_start cycle; dut0 must stay dark with a 48-clock frame_start period
  task automatic check_dark(input int frames, input string tag);
    int bad = 0;
    int fsbad = 0;
    for (int f = 0; f < frames; f++) begin
      for (int k = 1; k <= 48; k++) begin
        @(negedge clk);
        if (seg0 !== 8'hFF || dig0 !== 3'b000) bad++;
        if (fs0 !== 1'(k == 48)) fsbad++;
      end
    end
    chk({tag, "_dark"}, bad, 0);
    chk({tag, "_fs_period"}, fsbad, 0);
  endtask

  initial begin
    int n;
    int stale;
    int cnt[3];
    int segbad;
    int litbad;

    reset = 1'b1; load = 1'b0; load2 = 1'b0; bright = 4'hF;
    hex = '0; dp = '0; blank = '0; hex2 = '0; dp2 = '0; blank2 = '0;
    repeat (3) @(negedge clk);
    chk("rst_seg0", seg0, 8'hFF);
    chk("rst_dig0", dig0, 3'b000);
    chk("rst_fs0", fs0, 0);
    chk("rst_seg2", seg2, 8'hFF);
    chk("rst_dig2", dig2, 5'b00000);

    reset = 1'b0;
    @(negedge clk);
    chk("post_reset_fs0", fs0, 1);
    chk("post_reset_fs2", fs2, 1);
    chk("post_reset_dark", {seg0, 5'b0, dig0}, {8'hFF, 8'h00});
    wait_fs(0, 100, "first_wrap");
    check_dark(2, "no_load");

    // First load mid-frame; dut2 gets digits 0..4 = nibble value i
    hex = 12'h3A1; dp = 3'b010; blank = 3'b000;
    hex2 = 20'h43210; dp2 = 5'b10000; blank2 = 5'b00000;
    load = 1'b1; load2 = 1'b1;
    push0(hex, dp, blank);
    for (int i = 0; i < 5; i++) sb2.push_back(mk(hex2[4*i +: 4], dp2[i], blank2[i], i));
    @(negedge clk);
    load = 1'b0; load2 = 1'b0;
    wait_fs(0, 100, "load1_wrap");
    check_frame(0, 3, "frame_3a1");

    // Two loads within one frame: only the later one may ever appear
    repeat (10) @(negedge clk);
    hex = 12'h123; dp = 3'b000; blank = 3'b000; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (10) @(negedge clk);
    hex = 12'h456; load = 1'b1;
    push0(hex, dp, blank);
    @(negedge clk);
    load = 1'b0;
    n = 0; stale = 0;
    do begin
      @(negedge clk);
      n++;
      if (dig0 === 3'b001 && seg0 !== ~8'h06) stale++;
    end while (fs0 !== 1'b1 && n < 100);
    chk("dbl_wrap_seen", fs0, 1);
    chk("dbl_old_kept", stale, 0);
    check_frame(0, 3, "frame_456");

    // Pending load early in the frame, then a load on the wrap tick itself
    for (int k = 1; k <= 48; k++) begin
      @(negedge clk);
      if (k == 5) begin
        hex = 12'hBCD; dp = 3'b000; blank = 3'b000; load = 1'b1;
      end else if (k == 6) begin
        load = 1'b0;
      end else if (k == 47) begin
        hex = 12'hE0F; dp = 3'b101; blank = 3'b010; load = 1'b1;
        push0(hex, dp, blank);
      end else if (k == 48) begin
        load = 1'b0;
      end
    end
    chk("wrap_load_fs", fs0, 1);
    check_frame(0, 3, "frame_wrapload");
    push0(12'hE0F, 3'b101, 3'b010);
    check_frame(0, 3, "frame_wrapload_hold");

    // Five-digit scan: one-hot walk 0..4 and an 80-clock frame
    wait_fs(2, 200, "n5_wrap");
    check_frame(2, 5, "frame_n5");

    // PWM on the 64-clock-slot instance
    @(negedge clk);
    hex = 12'h888; dp = 3'b000; blank = 3'b000; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    bright = 4'd4;
    wait_fs(1, 400, "b4_wrap");
    cnt = '{0, 0, 0};
    segbad = 0;
    for (int k = 1; k <= 192; k++) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) if (dig1 === 3'(1 << d)) cnt[d]++;
      if (dig1 !== 3'b000 && seg1 !== 8'h80) segbad++;
      if (dig1 === 3'b000 && seg1 !== 8'hFF) segbad++;
    end
    chk("b4_lit_d0", cnt[0], 16);
    chk("b4_lit_d1", cnt[1], 16);
    chk("b4_lit_d2", cnt[2], 16);
    chk("b4_seg", segbad, 0);
    chk("b4_frame_len", fs1, 1);

    bright = 4'd0;
    litbad = 0;
    for (int k = 1; k <= 192; k++) begin
      @(negedge clk);
      if (dig1 !== 3'b000 || seg1 !== 8'hFF || dig0 !== 3'b000 || seg0 !== 8'hFF) litbad++;
    end
    chk("b0_dark", litbad, 0);

    // Reset mid-scan with a load still pending
    bright = 4'hF;
    repeat (5) @(negedge clk);
    chk("lit_before_reset", {31'b0, dig0 !== 3'b000}, 32'd1);
    hex = 12'h777; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_seg0", seg0, 8'hFF);
    chk("midrst_dig0", dig0, 3'b000);
    chk("midrst_fs0", fs0, 0);
    chk("midrst_seg1", seg1, 8'hFF);
    chk("midrst_dig1", dig1, 3'b000);
    chk("midrst_seg2", seg2, 8'hFF);
    chk("midrst_dig2", dig2, 5'b00000);
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_release_fs0", fs0, 1);
    wait_fs(0, 100, "post_rst_wrap");
    check_dark(2, "after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
